// File: rtl/edge_detect_pkg.sv
// Shared types and defaults for the edge-detect pipeline blocks.
// Holds the frame-control FSM encoding, default image size and counter sizing helpers.
package edge_detect_pkg;

   localparam int DEF_WIDTH  = 720;
   localparam int DEF_HEIGHT = 540;

   typedef enum logic {
      S_RUN = 1'b0,
      S_EOF = 1'b1
   } state_t;

   // Counter width for a 0..n-1 range; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic is_border(input int col, input int row, input int w, input int h);
      return (row == 0) || (row == h - 1) || (col == 0) || (col == w - 1);
   endfunction

endpackage

// File: rtl/gray_expand_pixel_counter.sv
// pixel_counter: raster-order column/row position of the next pixel to be popped.
// last flags the bottom-right pixel so the owner can detect end of frame.
module pixel_counter
   import edge_detect_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      advance,
   output logic [cnt_w(WIDTH)-1:0]   col,
   output logic [cnt_w(HEIGHT)-1:0]  row,
   output logic                      last
);

   localparam int CW = cnt_w(WIDTH);
   localparam int RW = cnt_w(HEIGHT);
   localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic          w_col_end;
   logic          w_row_end;

   assign w_col_end = (r_col == COL_MAX);
   assign w_row_end = (r_row == ROW_MAX);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (advance) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign col  = r_col;
   assign row  = r_row;
   assign last = w_col_end && w_row_end;

endmodule

// File: rtl/gray_expand.sv
// gray_expand: moves gray pixels from an FWFT FIFO into an RGB FIFO as {g,g,g}.
// Define GRAY_EXPAND_BORDER_ZERO_EN to write the one-pixel frame border as zero.
module gray_expand
   import edge_detect_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int HEIGHT     = DEF_HEIGHT,
   parameter int DATA_WIDTH = 24
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [DATA_WIDTH/3-1:0]   in_dout,
   input  logic                      in_empty,
   output logic                      in_rd_en,
   output logic [DATA_WIDTH-1:0]     out_din,
   input  logic                      out_full,
   output logic                      out_wr_en,
   output logic                      frame_done,
   output state_t                    o_dbg_state,
   output logic [cnt_w(WIDTH)-1:0]   o_dbg_col,
   output logic [cnt_w(HEIGHT)-1:0]  o_dbg_row
);

   state_t                  r_state;
   logic                    r_valid;
   logic [DATA_WIDTH-1:0]   r_out_din;
   logic                    r_frame_done;

   logic                    w_pop;
   logic                    w_write;
   logic                    w_last;
   logic [cnt_w(WIDTH)-1:0] w_col;
   logic [cnt_w(HEIGHT)-1:0] w_row;
   logic [DATA_WIDTH-1:0]   w_pixel;

   // Handshake: upstream transfers on an edge where in_rd_en=1 (only while !in_empty);
   // downstream transfers on an edge where out_wr_en=1 (only while !out_full).
   // The single output slot may be refilled on the same edge it is drained.
   assign w_write = r_valid && !out_full;
   assign w_pop   = reset && (r_state == S_RUN) && !in_empty && (!r_valid || !out_full);

   pixel_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT)
   ) u_pixel_counter (
      .clock   (clock),
      .reset   (reset),
      .advance (w_pop),
      .col     (w_col),
      .row     (w_row),
      .last    (w_last)
   );

`ifdef GRAY_EXPAND_BORDER_ZERO_EN
   assign w_pixel = is_border(int'(w_col), int'(w_row), WIDTH, HEIGHT) ? '0 : {3{in_dout}};
`else
   assign w_pixel = {3{in_dout}};
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= S_RUN;
         r_valid      <= 1'b0;
         r_out_din    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (w_pop) begin
            r_out_din <= w_pixel;
            r_valid   <= 1'b1;
         end else if (w_write) begin
            r_valid <= 1'b0;
         end
         case (r_state)
            S_RUN: begin
               if (w_pop && w_last) begin
                  r_state <= S_EOF;
               end
            end
            S_EOF: begin
               // Nothing is popped here, so an empty slot means the last pixel is out.
               if (!r_valid) begin
                  r_frame_done <= 1'b1;
                  r_state      <= S_RUN;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end

   assign in_rd_en    = w_pop;
   assign out_wr_en   = w_write;
   assign out_din     = r_out_din;
   assign frame_done  = r_frame_done;
   assign o_dbg_state = r_state;
   assign o_dbg_col   = w_col;
   assign o_dbg_row   = w_row;

endmodule

// File: tb/tb_gray_expand.sv
// Testbench for gray_expand at WIDTH=4, HEIGHT=3 with randomized FIFO flow control.
// Honours GRAY_EXPAND_BORDER_ZERO_EN in its reference model when the build defines it.
module tb_gray_expand;
   import edge_detect_pkg::*;

   localparam int W    = 4;
   localparam int H    = 3;
   localparam int DW   = 24;
   localparam int CH   = DW / 3;
   localparam int NPIX = W * H;

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [CH-1:0]   in_dout = '0;
   logic            in_empty = 1'b1;
   logic            in_rd_en;
   logic [DW-1:0]   out_din;
   logic            out_full = 1'b0;
   logic            out_wr_en;
   logic            frame_done;
   state_t          dbg_state;
   logic [1:0]      dbg_col;
   logic [1:0]      dbg_row;

   gray_expand #(
      .WIDTH      (W),
      .HEIGHT     (H),
      .DATA_WIDTH (DW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .in_dout     (in_dout),
      .in_empty    (in_empty),
      .in_rd_en    (in_rd_en),
      .out_din     (out_din),
      .out_full    (out_full),
      .out_wr_en   (out_wr_en),
      .frame_done  (frame_done),
      .o_dbg_state (dbg_state),
      .o_dbg_col   (dbg_col),
      .o_dbg_row   (dbg_row)
   );

   always #5 clock = ~clock;

   // Upstream FIFO contents and model of pixels accepted but not yet written.
   logic [CH-1:0] src_q[$];
   logic [DW-1:0] exp_q[$];

   int  n_cmp = 0;
   int  n_mis = 0;
   int  cyc = 0;
   int  k = 0;
   int  fd_due = -1;
   int  frames_seen = 0;
   int  pops_seen = 0;
   bit  eof_pend = 1'b0;
   bit  pend_pop = 1'b0;
   bit  full_force = 1'b0;
   bit  full_rand = 1'b0;
   bit  empty_tog = 1'b0;
   bit  empty_rand = 1'b0;
   bit  hold_empty = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic refresh();
      in_empty = hold_empty | (src_q.size() == 0);
      in_dout  = (src_q.size() != 0) ? src_q[0] : '0;
   endtask

   task automatic drive();
      logic [CH-1:0] tmp;
      if (pend_pop) begin
         tmp = src_q.pop_front();
         pend_pop = 1'b0;
      end
      if (empty_tog) hold_empty = ~hold_empty;
      else hold_empty = empty_rand && ($urandom_range(0, 1) == 1);
      out_full = full_force | (full_rand && ($urandom_range(0, 2) == 0));
      refresh();
   endtask

   task automatic set_full(input bit b);
      full_force = b;
      out_full   = b;
   endtask

   task automatic load_ramp(input logic [CH-1:0] base);
      for (int i = 0; i < NPIX; i++) src_q.push_back(base + CH'(i));
      refresh();
   endtask

   task automatic load_const(input logic [CH-1:0] v);
      for (int i = 0; i < NPIX; i++) src_q.push_back(v);
      refresh();
   endtask

   task automatic load_rand(input int n);
      for (int i = 0; i < n; i++) src_q.push_back(CH'($urandom_range(0, 255)));
      refresh();
   endtask

   // Expected RGB word for the k-th pixel of a frame in raster order.
   function automatic logic [DW-1:0] model_pixel(input int idx, input logic [CH-1:0] g);
      int r;
      int c;
      r = idx / W;
      c = idx % W;
`ifdef GRAY_EXPAND_BORDER_ZERO_EN
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return '0;
`endif
      return {g, g, g};
   endfunction

   task automatic step();
      bit            blk;
      bit            exp_rd;
      bit            exp_wr;
      logic [DW-1:0] e;
      @(negedge clock);
      cyc++;
      blk    = eof_pend && (fd_due < 0 || cyc < fd_due);
      exp_rd = reset && !in_empty && !blk && (exp_q.size() == 0 || !out_full);
      chk("rd_en", in_rd_en, exp_rd);
      exp_wr = (exp_q.size() != 0) && !out_full;
      chk("wr_en", out_wr_en, exp_wr);
      if (exp_q.size() != 0 && out_full) chk("stall_hold", out_din, exp_q[0]);
      chk("frame_done", frame_done, cyc == fd_due);
      if (frame_done) frames_seen++;
      if (cyc == fd_due) begin
         eof_pend = 1'b0;
         fd_due   = -1;
      end
      if (out_wr_en && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("pixel", out_din, e);
         if (eof_pend && exp_q.size() == 0 && fd_due < 0) fd_due = cyc + 2;
      end
      if (in_rd_en && src_q.size() != 0) begin
         exp_q.push_back(model_pixel(k, src_q[0]));
         pend_pop = 1'b1;
         pops_seen++;
         k++;
         if (k == NPIX) begin
            k = 0;
            eof_pend = 1'b1;
         end
      end
      @(posedge clock);
      #1;
      drive();
   endtask

   task automatic run_frames(input int target, input int budget);
      int n;
      n = 0;
      while (frames_seen < target && n < budget) begin
         step();
         n++;
      end
      chk("frame_timeout", frames_seen >= target, 1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_rd_en", in_rd_en, 0);
      chk("rst_wr_en", out_wr_en, 0);
      chk("rst_out_din", out_din, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_state", dbg_state, S_RUN);
      chk("rst_col", dbg_col, 0);
      chk("rst_row", dbg_row, 0);
   endtask

   initial begin
      int start;
      int n;
      // Reset with data already waiting upstream: nothing may move.
      load_ramp(8'h10);
      #2;
      check_reset_outputs();
      step();
      step();
      reset = 1'b1;

      // Streaming frame 0x10..0x1B.
      run_frames(1, 40);
      chk("src_after_stream", src_q.size(), 0);

      // Backpressure for 5 cycles mid-frame.
      load_rand(NPIX);
      repeat (4) step();
      set_full(1'b1);
      repeat (5) step();
      set_full(1'b0);
      run_frames(2, 60);

      // Two frames back-to-back.
      load_rand(2 * NPIX);
      run_frames(4, 100);
      chk("boundary_col", dbg_col, 0);
      chk("boundary_row", dbg_row, 0);

      // Mid-frame reset after 7 pixels.
      load_rand(NPIX);
      start = pops_seen;
      n = 0;
      while (pops_seen - start < 7 && n < 40) begin
         step();
         n++;
      end
      chk("pre_reset_pops", pops_seen - start, 7);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      src_q.delete();
      k = 0;
      eof_pend = 1'b0;
      fd_due = -1;
      load_rand(NPIX);
      step();
      step();
      reset = 1'b1;
      run_frames(5, 40);

      // Upstream empty toggling every cycle.
      empty_tog = 1'b1;
      load_rand(NPIX);
      run_frames(6, 80);
      empty_tog = 1'b0;

      // Uniform 0x80 frame exercises the border rule.
      load_const(8'h80);
      run_frames(7, 40);

      // Random flow control on both sides.
      empty_rand = 1'b1;
      full_rand = 1'b1;
      load_rand(3 * NPIX);
      run_frames(10, 600);
      empty_rand = 1'b0;
      full_rand = 1'b0;
      repeat (3) step();

      chk("frames_total", frames_seen, 10);
      chk("src_drained", src_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
